// File: rtl/mmu_tlb_port_arbiter.sv
// mmu_tlb_port_arbiter
//   Owns the shared lTlb/sTlb lookup port of one vFPGA. N_REQ translation FSMs
//   take exclusive lookup ownership through lock_req/unlock, served round-robin.
//   The TLB-update stream is only let through when no lookup owns the port, so
//   an update never lands while a lookup is in flight.
//
// Ports
//   aclk, aresetn   clock, synchronous active-low reset
//   lock_req[N]     level request per requester, held until granted
//   unlock[N]       one-cycle release pulse; ignored unless from the owner
//   grant[N]        registered one-hot owner, zero when idle or updating
//   sel             lookup-mux select, current or last owner index
//   s_upd_*         update stream from the TLB slave (tvalid/tready/tlast)
//   m_upd_*         update stream to tlb_controller (tvalid/tready)
//   busy            arbiter not idle
//   hold_err        sticky, an owner held the lock for MAX_HOLD cycles
module mmu_tlb_port_arbiter #(
   parameter int N_REQ    = 2,
   parameter int MAX_HOLD = 1024,
   parameter int CNT_BITS = 16
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [N_REQ-1:0]         lock_req,
   input  logic [N_REQ-1:0]         unlock,
   output logic [N_REQ-1:0]         grant,
   output logic [$clog2(N_REQ)-1:0] sel,
   input  logic                     s_upd_tvalid,
   output logic                     s_upd_tready,
   input  logic                     s_upd_tlast,
   output logic                     m_upd_tvalid,
   input  logic                     m_upd_tready,
   output logic                     busy,
   output logic                     hold_err
);

   localparam int SEL_W = $clog2(N_REQ);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOCK,
      ST_UPD
   } state_t;

   state_t              state, state_nxt;
   logic [N_REQ-1:0]    grant_nxt;
   logic [SEL_W-1:0]    sel_nxt;
   logic [SEL_W-1:0]    rr_ptr, rr_nxt;
   logic                upd_pri, pri_nxt;
   logic [CNT_BITS-1:0] hold_cnt, cnt_nxt;
   logic                err_nxt;

   logic [N_REQ-1:0]    eff_req;
   logic                win_found;
   logic [SEL_W-1:0]    win_idx;
   logic                owner_unlock;
   logic                upd_last;
   logic                enter_lock;

   // Round-robin pick starting at rr_ptr. A requester pulsing unlock has its
   // request masked for that cycle, so a releasing owner cannot re-win at once.
   // First pass covers rr_ptr..N_REQ-1, second pass wraps to 0..rr_ptr-1.
   always_comb begin
      eff_req   = lock_req & ~unlock;
      win_found = 1'b0;
      win_idx   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!win_found && eff_req[i] && (i >= 32'(rr_ptr))) begin
            win_found = 1'b1;
            win_idx   = SEL_W'(i);
         end
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!win_found && eff_req[i]) begin
            win_found = 1'b1;
            win_idx   = SEL_W'(i);
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      sel_nxt      = sel;
      rr_nxt       = rr_ptr;
      pri_nxt      = upd_pri;
      cnt_nxt      = hold_cnt;
      err_nxt      = hold_err;
      enter_lock   = 1'b0;
      owner_unlock = |(unlock & grant);
      upd_last     = s_upd_tvalid && m_upd_tready && s_upd_tlast;

      case (state)
         ST_IDLE: begin
            if (s_upd_tvalid && (!(|eff_req) || upd_pri)) begin
               state_nxt = ST_UPD;
            end else if (win_found) begin
               enter_lock = 1'b1;
            end
         end
         ST_LOCK: begin
            if (hold_cnt != '1) begin
               cnt_nxt = hold_cnt + CNT_BITS'(1);
            end
            if (cnt_nxt == CNT_BITS'(MAX_HOLD)) begin
               err_nxt = 1'b1;
            end
            if (owner_unlock) begin
               grant_nxt = '0;
               if (s_upd_tvalid && upd_pri) begin
                  state_nxt = ST_UPD;
               end else if (win_found) begin
                  // direct handoff, no idle cycle between owners
                  enter_lock = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_UPD: begin
            if (upd_last) begin
               state_nxt = ST_IDLE;
               pri_nxt   = 1'b0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
         end
      endcase

      if (enter_lock) begin
         state_nxt          = ST_LOCK;
         grant_nxt          = '0;
         grant_nxt[win_idx] = 1'b1;
         sel_nxt            = win_idx;
         rr_nxt             = (win_idx == SEL_W'(N_REQ - 1)) ? '0 : win_idx + SEL_W'(1);
         pri_nxt            = 1'b1;
         cnt_nxt            = '0;
      end
   end

   // Update path gated by reset as well so a partial burst stops immediately.
   always_comb begin
      busy         = (state != ST_IDLE);
      s_upd_tready = aresetn && (state == ST_UPD) && m_upd_tready;
      m_upd_tvalid = aresetn && (state == ST_UPD) && s_upd_tvalid;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state    <= ST_IDLE;
         grant    <= '0;
         sel      <= '0;
         rr_ptr   <= '0;
         upd_pri  <= 1'b0;
         hold_cnt <= '0;
         hold_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         grant    <= grant_nxt;
         sel      <= sel_nxt;
         rr_ptr   <= rr_nxt;
         upd_pri  <= pri_nxt;
         hold_cnt <= cnt_nxt;
         hold_err <= err_nxt;
      end
   end

endmodule

// File: tb/tb_mmu_tlb_port_arbiter.sv
// Testbench for mmu_tlb_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_mmu_tlb_port_arbiter;

   localparam int N    = 3;
   localparam int MAXH = 16;
   localparam int CB   = 5;
   localparam int SW   = 2;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic [N-1:0]  lock_req;
   logic [N-1:0]  unlock;
   logic [N-1:0]  grant;
   logic [SW-1:0] sel;
   logic          s_upd_tvalid;
   logic          s_upd_tready;
   logic          s_upd_tlast;
   logic          m_upd_tvalid;
   logic          m_upd_tready;
   logic          busy;
   logic          hold_err;

   int checks = 0;
   int errors = 0;

   mmu_tlb_port_arbiter #(
      .N_REQ   (N),
      .MAX_HOLD(MAXH),
      .CNT_BITS(CB)
   ) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .lock_req    (lock_req),
      .unlock      (unlock),
      .grant       (grant),
      .sel         (sel),
      .s_upd_tvalid(s_upd_tvalid),
      .s_upd_tready(s_upd_tready),
      .s_upd_tlast (s_upd_tlast),
      .m_upd_tvalid(m_upd_tvalid),
      .m_upd_tready(m_upd_tready),
      .busy        (busy),
      .hold_err    (hold_err)
   );

   always #5 aclk = ~aclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic do_reset();
      aresetn      = 1'b0;
      lock_req     = '0;
      unlock       = '0;
      s_upd_tvalid = 1'b0;
      s_upd_tlast  = 1'b0;
      m_upd_tready = 1'b1;
      tick();
      tick();
      aresetn = 1'b1;
   endtask

   task automatic test_reset();
      aresetn      = 1'b0;
      lock_req     = '1;
      unlock       = '0;
      s_upd_tvalid = 1'b1;
      s_upd_tlast  = 1'b0;
      m_upd_tready = 1'b1;
      tick();
      tick();
      checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b want 000", grant); end
      checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", sel); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (hold_err !== 1'b0) begin errors++; $display("FAIL reset_hold_err: got %b want 0", hold_err); end
      checks++; if (s_upd_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", s_upd_tready); end
      checks++; if (m_upd_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_upd_tvalid); end
      lock_req     = '0;
      s_upd_tvalid = 1'b0;
      aresetn      = 1'b1;
   endtask

   // request at cycle 0, grant at 1, unlock at 5, idle at 6
   task automatic test_lock_unlock();
      do_reset();
      lock_req = 3'b001;
      tick();
      lock_req = 3'b000;
      checks++; if (grant !== 3'b001) begin errors++; $display("FAIL lu_grant: got %b want 001", grant); end
      checks++; if (sel !== 2'd0) begin errors++; $display("FAIL lu_sel: got %0d want 0", sel); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lu_busy: got %b want 1", busy); end
      repeat (4) tick();
      checks++; if (grant !== 3'b001) begin errors++; $display("FAIL lu_hold: got %b want 001", grant); end
      unlock = 3'b001;
      tick();
      unlock = 3'b000;
      checks++; if (grant !== 3'b000) begin errors++; $display("FAIL lu_release: got %b want 000", grant); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lu_idle: got %b want 0", busy); end
   endtask

   // two requesters held high, each owner releases after 3 cycles
   task automatic test_back_to_back();
      logic [N-1:0] exp;
      do_reset();
      lock_req = 3'b011;
      tick();
      for (int j = 0; j < 4; j++) begin
         exp = (j % 2 == 0) ? 3'b001 : 3'b010;
         for (int c = 0; c < 3; c++) begin
            checks++; if (grant !== exp) begin errors++; $display("FAIL b2b_grant owner%0d cyc%0d: got %b want %b", j, c, grant, exp); end
            if (c == 2) begin
               unlock = exp;
               if (j == 3) lock_req = 3'b000;
            end
            tick();
            unlock = 3'b000;
         end
      end
      checks++; if (grant !== 3'b000) begin errors++; $display("FAIL b2b_end_grant: got %b want 000", grant); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy: got %b want 0", busy); end
   endtask

   // update waiting behind owner 0 goes ahead of the pending requester 1
   task automatic test_update_priority();
      do_reset();
      lock_req = 3'b001;
      tick();
      lock_req = 3'b000;
      checks++; if (grant !== 3'b001) begin errors++; $display("FAIL up_grant0: got %b want 001", grant); end
      lock_req     = 3'b010;
      s_upd_tvalid = 1'b1;
      s_upd_tlast  = 1'b0;
      m_upd_tready = 1'b1;
      @(negedge aclk);
      checks++; if (s_upd_tready !== 1'b0) begin errors++; $display("FAIL up_lock_tready: got %b want 0", s_upd_tready); end
      checks++; if (m_upd_tvalid !== 1'b0) begin errors++; $display("FAIL up_lock_tvalid: got %b want 0", m_upd_tvalid); end
      tick();
      checks++; if (grant !== 3'b001) begin errors++; $display("FAIL up_still_owner: got %b want 001", grant); end
      unlock = 3'b001;
      tick();
      unlock = 3'b000;
      checks++; if (grant !== 3'b000) begin errors++; $display("FAIL up_upd_grant: got %b want 000", grant); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL up_upd_busy: got %b want 1", busy); end
      checks++; if (sel !== 2'd0) begin errors++; $display("FAIL up_upd_sel: got %0d want 0", sel); end
      @(negedge aclk);
      checks++; if (s_upd_tready !== 1'b1) begin errors++; $display("FAIL up_beat1_tready: got %b want 1", s_upd_tready); end
      checks++; if (m_upd_tvalid !== 1'b1) begin errors++; $display("FAIL up_beat1_tvalid: got %b want 1", m_upd_tvalid); end
      tick();
      s_upd_tlast = 1'b1;
      @(negedge aclk);
      checks++; if (s_upd_tready !== 1'b1) begin errors++; $display("FAIL up_beat2_tready: got %b want 1", s_upd_tready); end
      tick();
      s_upd_tvalid = 1'b0;
      s_upd_tlast  = 1'b0;
      checks++; if (grant !== 3'b000) begin errors++; $display("FAIL up_idle_grant: got %b want 000", grant); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL up_idle_busy: got %b want 0", busy); end
      tick();
      lock_req = 3'b000;
      checks++; if (grant !== 3'b010) begin errors++; $display("FAIL up_grant1: got %b want 010", grant); end
      checks++; if (sel !== 2'd1) begin errors++; $display("FAIL up_sel1: got %0d want 1", sel); end
   endtask

   // update blocked for a whole LOCK period, then 3 beats under back-pressure
   task automatic test_backpressure();
      int sent;
      int seen;
      do_reset();
      lock_req     = 3'b001;
      s_upd_tvalid = 1'b1;
      s_upd_tlast  = 1'b0;
      m_upd_tready = 1'b1;
      tick();
      lock_req = 3'b000;
      checks++; if (grant !== 3'b001) begin errors++; $display("FAIL bp_grant: got %b want 001", grant); end
      for (int c = 0; c < 4; c++) begin
         @(negedge aclk);
         checks++; if (s_upd_tready !== 1'b0) begin errors++; $display("FAIL bp_lock_tready cyc%0d: got %b want 0", c, s_upd_tready); end
         checks++; if (m_upd_tvalid !== 1'b0) begin errors++; $display("FAIL bp_lock_tvalid cyc%0d: got %b want 0", c, m_upd_tvalid); end
         if (c == 3) unlock = 3'b001;
         tick();
         unlock = 3'b000;
      end
      sent = 0;
      seen = 0;
      for (int c = 0; c < 8 && sent < 3; c++) begin
         m_upd_tready = (c % 2 == 0);
         s_upd_tlast  = (sent == 2);
         @(negedge aclk);
         checks++; if (s_upd_tready !== m_upd_tready) begin errors++; $display("FAIL bp_tready cyc%0d: got %b want %b", c, s_upd_tready, m_upd_tready); end
         checks++; if (m_upd_tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid cyc%0d: got %b want 1", c, m_upd_tvalid); end
         if (s_upd_tready && m_upd_tvalid) seen++;
         if (m_upd_tready) sent++;
         tick();
      end
      s_upd_tvalid = 1'b0;
      s_upd_tlast  = 1'b0;
      m_upd_tready = 1'b1;
      checks++; if (seen != 3) begin errors++; $display("FAIL bp_beats: got %0d want 3", seen); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_end_busy: got %b want 0", busy); end
   endtask

   // owner keeps the lock past MAX_HOLD; a non-owner unlock is ignored
   task automatic test_hold_err();
      do_reset();
      lock_req = 3'b001;
      tick();
      lock_req = 3'b000;
      for (int g = 0; g < 40; g++) begin
         checks++; if (hold_err !== (g >= MAXH)) begin errors++; $display("FAIL he_flag g%0d: got %b want %b", g, hold_err, (g >= MAXH)); end
         checks++; if (grant !== 3'b001) begin errors++; $display("FAIL he_grant g%0d: got %b want 001", g, grant); end
         unlock = (g == 5) ? 3'b010 : 3'b000;
         tick();
      end
      unlock = 3'b001;
      tick();
      unlock = 3'b000;
      checks++; if (grant !== 3'b000) begin errors++; $display("FAIL he_release: got %b want 000", grant); end
      checks++; if (hold_err !== 1'b1) begin errors++; $display("FAIL he_sticky: got %b want 1", hold_err); end
   endtask

   // reset asserted after the first beat of a burst (hold_err still set from before)
   task automatic test_reset_mid_upd();
      s_upd_tvalid = 1'b1;
      s_upd_tlast  = 1'b0;
      m_upd_tready = 1'b1;
      tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_upd_busy: got %b want 1", busy); end
      @(negedge aclk);
      checks++; if (s_upd_tready !== 1'b1) begin errors++; $display("FAIL rm_beat1_tready: got %b want 1", s_upd_tready); end
      tick();
      aresetn = 1'b0;
      #1;
      checks++; if (s_upd_tready !== 1'b0) begin errors++; $display("FAIL rm_tready_now: got %b want 0", s_upd_tready); end
      tick();
      checks++; if (grant !== 3'b000) begin errors++; $display("FAIL rm_grant: got %b want 000", grant); end
      checks++; if (s_upd_tready !== 1'b0) begin errors++; $display("FAIL rm_tready: got %b want 0", s_upd_tready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
      checks++; if (hold_err !== 1'b0) begin errors++; $display("FAIL rm_hold_err: got %b want 0", hold_err); end
      aresetn      = 1'b1;
      s_upd_tvalid = 1'b0;
   endtask

   // random traffic against a transaction-level model of the arbiter
   task automatic test_random(input int n_cycles);
      int owner, last, rr, hold, w, burst_left, idx;
      bit in_upd, pri, err, do_take;
      logic [N-1:0] want, req, exp_grant;
      logic exp_busy, exp_tready, exp_tvalid;
      do_reset();
      owner = -1; last = 0; rr = 0; hold = 0;
      in_upd = 0; pri = 0; err = 0;
      want = '0; burst_left = 0;
      for (int cyc = 0; cyc < n_cycles; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!want[i] && owner != i && $urandom_range(3) == 0) want[i] = 1'b1;
         end
         lock_req = want;
         unlock   = '0;
         if (owner >= 0 && $urandom_range(3) == 0) unlock[owner] = 1'b1;
         if ($urandom_range(15) == 0) begin
            idx = $urandom_range(N - 1);
            unlock[idx] = 1'b1;
         end
         if (burst_left == 0 && $urandom_range(9) == 0) burst_left = 1 + $urandom_range(3);
         s_upd_tvalid = (burst_left > 0);
         s_upd_tlast  = (burst_left == 1);
         m_upd_tready = ($urandom_range(3) != 0);

         exp_grant  = (owner >= 0) ? (N'(1) << owner) : '0;
         exp_busy   = (owner >= 0) || in_upd;
         exp_tready = in_upd && m_upd_tready;
         exp_tvalid = in_upd && s_upd_tvalid;

         @(negedge aclk);
         checks++; if (grant !== exp_grant) begin errors++; $display("FAIL rnd_grant cyc%0d: got %b want %b", cyc, grant, exp_grant); end
         checks++; if (sel !== SW'(last)) begin errors++; $display("FAIL rnd_sel cyc%0d: got %0d want %0d", cyc, sel, last); end
         checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy cyc%0d: got %b want %b", cyc, busy, exp_busy); end
         checks++; if (hold_err !== err) begin errors++; $display("FAIL rnd_hold_err cyc%0d: got %b want %b", cyc, hold_err, err); end
         checks++; if (s_upd_tready !== exp_tready) begin errors++; $display("FAIL rnd_tready cyc%0d: got %b want %b", cyc, s_upd_tready, exp_tready); end
         checks++; if (m_upd_tvalid !== exp_tvalid) begin errors++; $display("FAIL rnd_tvalid cyc%0d: got %b want %b", cyc, m_upd_tvalid, exp_tvalid); end

         req     = lock_req & ~unlock;
         do_take = 1'b0;
         if (in_upd) begin
            if (s_upd_tvalid && m_upd_tready && s_upd_tlast) begin
               in_upd = 1'b0;
               pri    = 1'b0;
            end
         end else if (owner < 0) begin
            if (s_upd_tvalid && (req == 0 || pri)) in_upd = 1'b1;
            else if (req != 0) do_take = 1'b1;
         end else begin
            if (hold < (1 << CB) - 1) hold++;
            if (hold >= MAXH) err = 1'b1;
            if (unlock[owner]) begin
               if (s_upd_tvalid && pri) begin
                  owner  = -1;
                  in_upd = 1'b1;
               end else if (req != 0) begin
                  do_take = 1'b1;
               end else begin
                  owner = -1;
               end
            end
         end
         if (do_take) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
               if (w < 0 && req[(rr + k) % N]) w = (rr + k) % N;
            end
            owner = w;
            last  = w;
            rr    = (w + 1) % N;
            pri   = 1'b1;
            hold  = 0;
            if ($urandom_range(1) == 0) want[w] = 1'b0;
         end
         if (s_upd_tvalid && exp_tready) burst_left--;
         tick();
      end
      lock_req     = '0;
      unlock       = '0;
      s_upd_tvalid = 1'b0;
      s_upd_tlast  = 1'b0;
   endtask

   initial begin
      aresetn      = 1'b0;
      lock_req     = '0;
      unlock       = '0;
      s_upd_tvalid = 1'b0;
      s_upd_tlast  = 1'b0;
      m_upd_tready = 1'b1;
      test_reset();
      test_lock_unlock();
      test_back_to_back();
      test_update_priority();
      test_backpressure();
      test_hold_err();
      test_reset_mid_upd();
      test_random(2500);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
